tap_delay_line: RTL and testbench



---
 rtl/tap_delay_line.sv | 171 +++++++++++++++++
 tb/tb_tap_delay_line.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tap_delay_line.sv
// -----------------------------------------------------------------------------
// tap_delay_line
//
// Purpose:
//   WIDTH-bit, DEPTH-stage delay line with a runtime-selectable output tap.
//   Stages advance together when en=1 and hold when en=0. A valid bit travels
//   with every data word, so bubbles (d_valid=0) occupy slots like real data.
//   The tap select picks a delay of 0..DEPTH cycles. sel=0 is a combinational
//   bypass of d/d_valid. Select values above DEPTH are clamped to DEPTH.
//
// Parameters:
//   WIDTH  data width in bits (>=1)
//   DEPTH  number of register stages (>=1). This is the maximum delay.
//   SEL_W  tap-select / occupancy width. It is derived from DEPTH and must be
//          left at its default value.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset. Clears all stages and
//                   valids, and takes priority over en.
//   en         in   shift enable. All stages advance only when en=1.
//   d          in   WIDTH   data in
//   d_valid    in   qualifier for d. It is shifted alongside the data.
//   sel        in   SEL_W   tap select. 0 = bypass, k = output of stage k-1.
//   q          out  WIDTH   selected tap data
//   q_valid    out  valid bit of the selected tap
//   primed     out  all DEPTH stage valid bits are set
//   occupancy  out  SEL_W   number of stages holding a valid word (0..DEPTH)
//
// Build option:
//   TAP_DELAY_LINE_OUT_REG_EN
//     Defined:   q/q_valid are registered after the tap mux. The output
//                register loads every cycle regardless of en, so total latency
//                is sel+1. Reset clears the output register. primed and
//                occupancy stay combinational from the stage valids.
//     Undefined: the tap mux drives q/q_valid directly.
// -----------------------------------------------------------------------------
module tap_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3,
  parameter int SEL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  input  logic [SEL_W-1:0] sel,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic             primed,
  output logic [SEL_W-1:0] occupancy
);

  // Largest legal tap index. It is also the occupancy value that means "full".
  localparam logic [SEL_W-1:0] MAX_TAP = SEL_W'(DEPTH);

  // ---------------------------------------------------------------------------
  // Stage storage
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] r_stage [DEPTH];
  logic [DEPTH-1:0] r_vld;

  // Shift inputs for each stage. Stage 0 takes the port; every later stage
  // takes its predecessor.
  logic [WIDTH-1:0] w_stage_in [DEPTH];
  logic [DEPTH-1:0] w_vld_in;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_shift_in
      if (gi == 0) begin : g_head
        assign w_stage_in[gi] = d;
        assign w_vld_in[gi]   = d_valid;
      end else begin : g_body
        assign w_stage_in[gi] = r_stage[gi-1];
        assign w_vld_in[gi]   = r_vld[gi-1];
      end
    end
  endgenerate

  // All stages move in lockstep. Data shifts even when d_valid=0, so a bubble
  // keeps its place in the stream. Reset overrides en.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= '0;
      end
      r_vld <= '0;
    end else if (en) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= w_stage_in[i];
      end
      r_vld <= w_vld_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Tap mux
  // ---------------------------------------------------------------------------
  // Tap 0 is the live input. Tap k (1..DEPTH) is the output of stage k-1.
  // The table has DEPTH+1 entries, so a SEL_W-bit index addresses it exactly.
  logic [WIDTH-1:0] w_tap_data [DEPTH+1];
  logic [DEPTH:0]   w_tap_vld;

  assign w_tap_data[0] = d;
  assign w_tap_vld[0]  = d_valid;

  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_taps
      assign w_tap_data[gi+1] = r_stage[gi];
      assign w_tap_vld[gi+1]  = r_vld[gi];
    end
  endgenerate

  // When DEPTH+1 is not a power of two, sel can encode taps that do not
  // exist. Clamping them to the deepest tap keeps the index in range, so no
  // X can leak from an out-of-range array read.
  logic [SEL_W-1:0] w_sel_clamp;
  logic [WIDTH-1:0] w_mux_data;
  logic             w_mux_vld;

  assign w_sel_clamp = (sel > MAX_TAP) ? MAX_TAP : sel;
  assign w_mux_data  = w_tap_data[w_sel_clamp];
  assign w_mux_vld   = w_tap_vld[w_sel_clamp];

  // ---------------------------------------------------------------------------
  // Occupancy / primed
  // ---------------------------------------------------------------------------
  // Prefix-sum chain over the stage valids. w_cnt[k] counts the valids in
  // stages 0..k-1, so w_cnt[DEPTH] is the full popcount.
  logic [SEL_W-1:0] w_cnt [DEPTH+1];

  assign w_cnt[0] = '0;

  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_popcount
      assign w_cnt[gi+1] = w_cnt[gi] + SEL_W'(r_vld[gi]);
    end
  endgenerate

  assign occupancy = w_cnt[DEPTH];
  assign primed    = (w_cnt[DEPTH] == MAX_TAP);

  // ---------------------------------------------------------------------------
  // Output stage
  // ---------------------------------------------------------------------------
`ifdef TAP_DELAY_LINE_OUT_REG_EN
  // The output register is free-running and ignores en. Whatever the mux
  // shows this cycle, including a live bypass, appears on q next cycle.
  logic [WIDTH-1:0] r_q;
  logic             r_q_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q       <= '0;
      r_q_valid <= 1'b0;
    end else begin
      r_q       <= w_mux_data;
      r_q_valid <= w_mux_vld;
    end
  end

  assign q       = r_q;
  assign q_valid = r_q_valid;
`else
  assign q       = w_mux_data;
  assign q_valid = w_mux_vld;
`endif

endmodule

// File: tb/tb_tap_delay_line.sv
// -----------------------------------------------------------------------------
// tb_tap_delay_line
//
// Two instances share one stimulus stream:
//   u_dut3  WIDTH=8, DEPTH=3. Every sel value 0..3 is a real tap.
//   u_dut2  WIDTH=8, DEPTH=2. sel=3 exercises the clamp to tap 2.
//
// Reference model:
//   The model keeps a history of (d, d_valid) pairs. A pair is pushed at the
//   front on each enabled edge, and the history is emptied on reset.
//   - Tap k returns the pair from k enabled edges ago. A slot beyond the
//     recorded history reads as zero.
//   - Occupancy counts the valid pairs among the newest DEPTH entries.
//
// The driver pushes the expected outputs for the cycle into a queue. The
// monitor pops one entry on every falling edge and compares it against both
// DUTs.
// -----------------------------------------------------------------------------
module tb_tap_delay_line;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [7:0] d;
  logic       d_valid;
  logic [1:0] sel;

  logic [7:0] q3, q2;
  logic       qv3, qv2, pr3, pr2;
  logic [1:0] oc3, oc2;

  always #5 clk = ~clk;

  tap_delay_line #(.WIDTH(8), .DEPTH(3)) u_dut3 (
    .clk(clk), .reset(reset), .en(en), .d(d), .d_valid(d_valid), .sel(sel),
    .q(q3), .q_valid(qv3), .primed(pr3), .occupancy(oc3)
  );

  tap_delay_line #(.WIDTH(8), .DEPTH(2)) u_dut2 (
    .clk(clk), .reset(reset), .en(en), .d(d), .d_valid(d_valid), .sel(sel),
    .q(q2), .q_valid(qv2), .primed(pr2), .occupancy(oc2)
  );

  typedef struct {
    logic [7:0] d;
    logic       v;
  } entry_t;

  typedef struct {
    logic [7:0] q3;
    logic       qv3;
    logic       pr3;
    logic [1:0] oc3;
    logic [7:0] q2;
    logic       qv2;
    logic       pr2;
    logic [1:0] oc2;
    int         cyc;
  } exp_t;

  entry_t hist[$];
  exp_t   exp_q[$];
  entry_t oreg3, oreg2;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Tap k (clamped to depth) returns the word from k enabled edges ago.
  function automatic entry_t model_tap(input int depth, input int s,
                                       input logic [7:0] dd, input logic v);
    entry_t e;
    int     k;
    k = (s > depth) ? depth : s;
    e.d = 8'h00;
    e.v = 1'b0;
    if (k == 0) begin
      e.d = dd;
      e.v = v;
    end else if (k <= hist.size()) begin
      e = hist[k-1];
    end
    return e;
  endfunction

  function automatic int model_occ(input int depth);
    int n = 0;
    for (int i = 0; i < hist.size() && i < depth; i++) begin
      if (hist[i].v) n++;
    end
    return n;
  endfunction

  task automatic check(input string name, input logic [7:0] act,
                       input logic [7:0] expv, input int c);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, act, expv);
    end
  endtask

  // Drives one cycle of stimulus, queues the expectation, then advances the
  // model across the rising edge.
  task automatic step(input logic r, input logic e, input logic [7:0] dd,
                      input logic v, input logic [1:0] s, input bit chk);
    exp_t   x;
    entry_t t3, t2;
    reset   = r;
    en      = e;
    d       = dd;
    d_valid = v;
    sel     = s;
    t3 = model_tap(3, int'(s), dd, v);
    t2 = model_tap(2, int'(s), dd, v);
`ifdef TAP_DELAY_LINE_OUT_REG_EN
    x.q3 = oreg3.d;  x.qv3 = oreg3.v;
    x.q2 = oreg2.d;  x.qv2 = oreg2.v;
`else
    x.q3 = t3.d;     x.qv3 = t3.v;
    x.q2 = t2.d;     x.qv2 = t2.v;
`endif
    x.oc3 = 2'(model_occ(3));
    x.pr3 = (model_occ(3) == 3);
    x.oc2 = 2'(model_occ(2));
    x.pr2 = (model_occ(2) == 2);
    x.cyc = cyc;
    if (chk) exp_q.push_back(x);
    @(posedge clk);
    if (r) begin
      oreg3 = '{8'h00, 1'b0};
      oreg2 = '{8'h00, 1'b0};
      hist.delete();
    end else begin
      oreg3 = t3;
      oreg2 = t2;
      if (e) begin
        entry_t n;
        n.d = dd;
        n.v = v;
        hist.push_front(n);
        if (hist.size() > 3) void'(hist.pop_back());
      end
    end
    cyc++;
    #1;
  endtask

  // Monitor: one comparison set per presented cycle.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        x = exp_q.pop_front();
        $display("cyc %0d rst=%0b en=%0b sel=%0d d=%02h/%0b | q3=%02h/%0b occ3=%0d pr3=%0b | q2=%02h/%0b occ2=%0d pr2=%0b",
                 x.cyc, reset, en, sel, d, d_valid, q3, qv3, oc3, pr3, q2, qv2, oc2, pr2);
        check("q3",         q3,          x.q3,          x.cyc);
        check("q_valid3",   {7'b0, qv3}, {7'b0, x.qv3}, x.cyc);
        check("primed3",    {7'b0, pr3}, {7'b0, x.pr3}, x.cyc);
        check("occupancy3", {6'b0, oc3}, {6'b0, x.oc3}, x.cyc);
        check("q2",         q2,          x.q2,          x.cyc);
        check("q_valid2",   {7'b0, qv2}, {7'b0, x.qv2}, x.cyc);
        check("primed2",    {7'b0, pr2}, {7'b0, x.pr2}, x.cyc);
        check("occupancy2", {6'b0, oc2}, {6'b0, x.oc2}, x.cyc);
      end
    end
  end

  // Watchdog: the stimulus is bounded, so this firing means something hung.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] cnt;
    oreg3 = '{8'h00, 1'b0};
    oreg2 = '{8'h00, 1'b0};

    // Reset for two cycles. Outputs are undefined before the first edge.
    step(1, 0, 8'h00, 0, 2'd0, 0);
    step(1, 0, 8'h00, 0, 2'd0, 1);

    // Bypass: same-cycle passthrough while empty.
    step(0, 0, 8'hA5, 1, 2'd0, 1);

    // Latency per tap with a counting stream.
    cnt = 8'd1;
    for (int s = 0; s < 4; s++) begin
      for (int n = 0; n < 5; n++) begin
        step(0, 1, cnt, 1, 2'(s), 1);
        cnt++;
      end
    end

    // Stall: fill 11/22/33, hold for four cycles while d changes, then resume.
    step(1, 0, 8'h00, 0, 2'd3, 1);
    step(0, 1, 8'h11, 1, 2'd3, 1);
    step(0, 1, 8'h22, 1, 2'd3, 1);
    step(0, 1, 8'h33, 1, 2'd3, 1);
    for (int n = 0; n < 4; n++) begin
      step(0, 0, 8'(8'hC0 + n), 1, 2'd3, 1);
    end
    step(0, 1, 8'h44, 1, 2'd3, 1);
    step(0, 1, 8'h55, 1, 2'd3, 1);

    // Bubbles: valid pattern 1,0,1 observed at tap 2.
    step(1, 0, 8'h00, 0, 2'd2, 1);
    step(0, 1, 8'h10, 1, 2'd2, 1);
    step(0, 1, 8'hFF, 0, 2'd2, 1);
    step(0, 1, 8'h30, 1, 2'd2, 1);
    step(0, 1, 8'h40, 0, 2'd2, 1);
    step(0, 1, 8'h50, 0, 2'd2, 1);
    step(0, 1, 8'h60, 0, 2'd2, 1);

    // Clamp (DEPTH=2 instance at sel=3), then a reset pulse with en=1.
    step(0, 1, 8'h71, 1, 2'd3, 1);
    step(0, 1, 8'h72, 1, 2'd3, 1);
    step(0, 1, 8'h73, 1, 2'd3, 1);
    step(0, 0, 8'h74, 1, 2'd3, 1);
    step(1, 1, 8'h75, 1, 2'd3, 1);
    step(0, 0, 8'h76, 1, 2'd3, 1);
    step(0, 0, 8'h77, 1, 2'd0, 1);
    step(0, 1, 8'h78, 1, 2'd1, 1);
    step(0, 0, 8'h79, 1, 2'd1, 1);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 39) == 0),
           ($urandom_range(0, 3) != 0),
           8'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)), 1);
    end

    // Let the monitor drain the last expectation.
    @(negedge clk);
    #1;
    check("queue_drained", 8'(exp_q.size()), 8'd0, cyc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
